irq_ctrl: RTL
=============

# irq_ctrl

Parametrised interrupt controller that replaces the single hard-wired keypress interrupt in the top level. It sits between the peripherals (keyboard, disk/UART, timers) and the CPU's `INTin`/`INTnum` pins. It takes NUM_IRQ asynchronous request lines, per-channel edge or level mode, mask, pending and fixed-priority claim, and enforces one in-service interrupt at a time through an explicit claim/EOI handshake. It is accessed through memory-mapped registers on the CPU bus.

## Interface
- NUM_IRQ, 8, number of request channels (1..31); channel 0 has highest priority.
- VEC_BASE, 1, vector reported for channel 0; channel i reports VEC_BASE+i (32-bit, modulo 2^32).
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- irq_in  in  NUM_IRQ  raw request lines, asynchronous to clk.
- addr  in  3  register select (already decoded chip-select folded into we/rd).
- wdata  in  32  write data.
- we  in  1  write strobe, one clk per access.
- rd  in  1  read strobe, one clk per access.
- rdata  out  32  read data, combinational from addr/rd and registered state; 0 when rd=0.
- int_req  out  1  interrupt request to CPU (`INTin`), registered.
- int_num  out  32  vector of the requesting channel (`INTnum`), registered.

## Operation
- Input path per channel: 2-flop synchronizer (s1, s2) plus history flop s3; rise = s2 & ~s3.
- Registers (bits above NUM_IRQ-1 read 0, writes ignored):
  - 0 MASK rw: 1 = enabled; reset 0 (all disabled).
  - 1 PENDING r / write-1-to-clear; reset 0.
  - 2 MODE rw: 1 = level, 0 = edge; reset 0.
  - 3 CLAIM r: in REQ returns {1'b1, int_num[30:0]}; otherwise 0. A read in REQ is the claim.
  - 4 EOI w: any write ends service.
  - 5-7: read 0, writes ignored.
- Pending, edge channel: set by rise; cleared by W1C or by a claim of that channel; if a set and a clear hit the same bit on the same edge, set wins.
- Pending, level channel: pending[i] = s2[i] every cycle; W1C and claim have no effect.
- Winner: lowest index i with pending[i] & mask[i].
- FSM states:
  - IDLE: int_req=0. Go to REQ when any pending&mask.
  - REQ: int_req=1, and int_num tracks the current winner each cycle. A claim read goes to SERVICE and clears the claimed channel's pending bit if it is edge mode. If pending&mask becomes 0 (mask write or W1C), return to IDLE.
  - SERVICE: int_req=0, int_num frozen. EOI goes to IDLE. No nesting: a claim read returns 0.
  - EOI outside SERVICE and claim outside REQ have no side effect.
- Reset values: state IDLE, int_req 0, int_num 0, MASK/PENDING/MODE 0, s1/s2/s3 0. A line already high when reset is released is seen as a rising edge.
- Reset asserted mid-service returns everything to reset values on that edge. The in-service interrupt is lost.
- Simultaneous we and rd: the write takes effect and the read returns pre-write data.

## Timing
- irq_in rises before edge k: s1 at k, s2 at k+1, pending at k+2, state REQ with int_req=1 and int_num valid at k+3 (mask already set). Latency is 3 clk.
- Register write at edge w: a mask change is reflected in int_req/int_num at w+1.
- Claim read at edge c: rdata is valid during the strobe cycle. State is SERVICE and int_req=0 from c+1.
- EOI at edge e: IDLE at e+1. If pending&mask is still nonzero, REQ and int_req=1 at e+2.
- Pulses shorter than one clk may be missed. Pulses of at least 1 clk are guaranteed to be seen.

## Test plan
- Reset, MASK=0xFF, pulse irq_in[3] for 2 clk -> int_req=1 exactly 3 clk after the rise, int_num=4. Then CLAIM reads 0x80000004, int_req=0 next clk, PENDING=0.
- irq_in[5] and irq_in[2] rise on the same clk -> int_num=3. Claim, then EOI -> int_req reasserts at EOI+2 with int_num=6.
- MODE[1]=1, irq_in[1] held high -> claim and EOI repeat int_num=2 until irq_in[1] drops. W1C of PENDING bit 1 has no effect.
- MASK=0, pulse irq_in[0] -> PENDING=0x1, int_req stays 0. Write MASK=1 -> int_req=1 next clk. Write PENDING=1 (W1C) -> IDLE, int_req=0.
- In SERVICE: a CLAIM read returns 0 and EOI in IDLE is ignored. Assert rst_n=0 for 1 clk with irq_in[4] held high -> all registers 0. After MASK=0x10, int_req=1 (edge re-detected).
- A rising edge on channel 2 on the same clk as a W1C of bit 2 -> PENDING bit 2 remains 1.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl - fixed-priority interrupt controller with claim/EOI handshake.
//
// Collects NUM_IRQ asynchronous request lines, latches them as edge or level
// requests, and presents the lowest-index enabled pending channel to the CPU
// as int_req/int_num. Only one interrupt is in service at a time: the CPU
// claims by reading CLAIM and releases by writing EOI.
//
// Ports
//   clk      system clock, rising edge
//   rst_n    synchronous active-low reset
//   irq_in   raw request lines, asynchronous to clk
//   addr     register select
//   wdata    write data
//   we, rd   single-cycle write / read strobes
//   rdata    read data, combinational, 0 when rd=0
//   int_req  registered interrupt request to the CPU
//   int_num  registered vector of the requesting channel
//
// Register map
//   0 MASK    rw   1 = channel enabled
//   1 PENDING r/w1c
//   2 MODE    rw   1 = level, 0 = edge
//   3 CLAIM   r    {1, int_num[30:0]} while requesting, else 0; the read claims
//   4 EOI     w    any write ends service
//   5-7            read 0
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | nothing presented to the CPU
// REQ     | int_req high, int_num follows the current winner
// SERVICE | claimed, int_num frozen until EOI

module irq_ctrl #(
   parameter int unsigned NUM_IRQ  = 8,
   parameter logic [31:0] VEC_BASE = 32'd1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic [2:0]         addr,
   input  logic [31:0]        wdata,
   input  logic               we,
   input  logic               rd,
   output logic [31:0]        rdata,
   output logic               int_req,
   output logic [31:0]        int_num
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_e;

   localparam logic [2:0] A_MASK  = 3'd0;
   localparam logic [2:0] A_PEND  = 3'd1;
   localparam logic [2:0] A_MODE  = 3'd2;
   localparam logic [2:0] A_CLAIM = 3'd3;
   localparam logic [2:0] A_EOI   = 3'd4;

   logic [NUM_IRQ-1:0] s1_q, s2_q, s3_q;
   logic [NUM_IRQ-1:0] mask_q, mask_d;
   logic [NUM_IRQ-1:0] pend_q, pend_d;
   logic [NUM_IRQ-1:0] mode_q, mode_d;
   state_e             state_q, state_d;
   logic               int_req_q, int_req_d;
   logic [31:0]        int_num_q, int_num_d;
   logic [4:0]         claim_idx_q, claim_idx_d;

   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] w1c;
   logic [NUM_IRQ-1:0] claim_clr;
   logic [NUM_IRQ-1:0] active;
   logic               win_vld;
   logic [4:0]         win_idx;
   logic               wr_mask, wr_pend, wr_mode, wr_eoi;
   logic               claim;

   // Register writes only ever use the low NUM_IRQ bits.
   logic unused_wdata;
   assign unused_wdata = ^wdata;

   assign wr_mask = we && (addr == A_MASK);
   assign wr_pend = we && (addr == A_PEND);
   assign wr_mode = we && (addr == A_MODE);
   assign wr_eoi  = we && (addr == A_EOI);
   assign claim   = rd && (addr == A_CLAIM) && (state_q == REQ);

   assign rise = s2_q & ~s3_q;
   assign w1c  = wr_pend ? wdata[NUM_IRQ-1:0] : '0;

   always_comb begin
      mask_d = mask_q;
      mode_d = mode_q;
      if (wr_mask) mask_d = wdata[NUM_IRQ-1:0];
      if (wr_mode) mode_d = wdata[NUM_IRQ-1:0];
   end

   always_comb begin
      claim_clr = '0;
      pend_d    = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         claim_clr[i] = claim && (claim_idx_q == 5'(i));
         // Edge channels: a new rise beats a same-cycle clear.
         if (mode_q[i]) pend_d[i] = s2_q[i];
         else           pend_d[i] = rise[i] | (pend_q[i] & ~w1c[i] & ~claim_clr[i]);
      end
   end

   // The FSM looks at the mask being written so that a mask write shows up on
   // int_req on the edge right after the write cycle.
   assign active = pend_q & mask_d;

   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (active[i]) begin
            win_vld = 1'b1;
            win_idx = 5'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (win_vld) state_d = REQ;
         REQ: begin
            if (claim)         state_d = SERVICE;
            else if (!win_vld) state_d = IDLE;
         end
         SERVICE: if (wr_eoi) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      int_req_d   = (state_d == REQ);
      int_num_d   = int_num_q;
      claim_idx_d = claim_idx_q;
      if (state_d == REQ) begin
         int_num_d   = VEC_BASE + {27'd0, win_idx};
         claim_idx_d = win_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q        <= '0;
         s2_q        <= '0;
         s3_q        <= '0;
         mask_q      <= '0;
         pend_q      <= '0;
         mode_q      <= '0;
         state_q     <= IDLE;
         int_req_q   <= 1'b0;
         int_num_q   <= '0;
         claim_idx_q <= '0;
      end else begin
         s1_q        <= irq_in;
         s2_q        <= s1_q;
         s3_q        <= s2_q;
         mask_q      <= mask_d;
         pend_q      <= pend_d;
         mode_q      <= mode_d;
         state_q     <= state_d;
         int_req_q   <= int_req_d;
         int_num_q   <= int_num_d;
         claim_idx_q <= claim_idx_d;
      end
   end

   // Reads see pre-write state, so a simultaneous we/rd returns the old value.
   always_comb begin
      rdata = '0;
      if (rd) begin
         case (addr)
            A_MASK:  rdata = {{(32-NUM_IRQ){1'b0}}, mask_q};
            A_PEND:  rdata = {{(32-NUM_IRQ){1'b0}}, pend_q};
            A_MODE:  rdata = {{(32-NUM_IRQ){1'b0}}, mode_q};
            A_CLAIM: rdata = (state_q == REQ) ? {1'b1, int_num_q[30:0]} : '0;
            default: rdata = '0;
         endcase
      end
   end

   assign int_req = int_req_q;
   assign int_num = int_num_q;

endmodule
